// File: rtl/palindrome_stats_if.sv
// Result handshake between palindrome_stats and its consumer.
// The statistics block is the master and the consumer is the slave.
interface palindrome_stats_if #(
  parameter int unsigned CNT_W = 5
);
  logic [CNT_W-1:0] cnt_o;
  logic [CNT_W-1:0] run_o;
  logic             valid_o;
  logic             ready_i;
  logic             drop_o;
  logic [7:0]       drop_cnt_o;

  modport master (
    output cnt_o, run_o, valid_o, drop_o, drop_cnt_o,
    input  ready_i
  );

  modport slave (
    input  cnt_o, run_o, valid_o, drop_o, drop_cnt_o,
    output ready_i
  );
endinterface

// File: rtl/palindrome_stats.sv
// Per-window hit count and longest hit run of the palindrome flag.
// Each result is offered on a valid/ready slot; results that arrive while the slot is still occupied are dropped.
module palindrome_stats #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  palindrome_i,
  palindrome_stats_if.master    res
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [7:0]       DROP_MAX = 8'hFF;

  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] cur_run_q;
  logic [CNT_W-1:0] max_run_q;

  logic [CNT_W-1:0] hit_nxt_c;
  logic [CNT_W-1:0] cur_nxt_c;
  logic [CNT_W-1:0] max_nxt_c;
  logic             eow_c;
  logic             slot_free_c;

  // Statistics including the sample taken on the current edge
  always_comb begin
    hit_nxt_c   = hit_q + CNT_W'(palindrome_i);
    cur_nxt_c   = palindrome_i ? (cur_run_q + CNT_W'(1)) : '0;
    max_nxt_c   = (cur_nxt_c > max_run_q) ? cur_nxt_c : max_run_q;
    eow_c       = (win_q == LAST_IDX);
    slot_free_c = !res.valid_o || res.ready_i;
  end

  // Window accumulation; the window counter never waits for the consumer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q     <= '0;
      hit_q     <= '0;
      cur_run_q <= '0;
      max_run_q <= '0;
    end else if (eow_c) begin
      win_q     <= '0;
      hit_q     <= '0;
      cur_run_q <= '0;
      max_run_q <= '0;
    end else begin
      win_q     <= win_q + CNT_W'(1);
      hit_q     <= hit_nxt_c;
      cur_run_q <= cur_nxt_c;
      max_run_q <= max_nxt_c;
    end
  end

  // Result slot: load when free, otherwise discard the new result and count it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res.cnt_o      <= '0;
      res.run_o      <= '0;
      res.valid_o    <= 1'b0;
      res.drop_o     <= 1'b0;
      res.drop_cnt_o <= '0;
    end else begin
      res.drop_o <= 1'b0;
      if (eow_c && slot_free_c) begin
        res.cnt_o   <= hit_nxt_c;
        res.run_o   <= max_nxt_c;
        res.valid_o <= 1'b1;
      end else if (eow_c) begin
        res.drop_o <= 1'b1;
        if (res.drop_cnt_o != DROP_MAX) begin
          res.drop_cnt_o <= res.drop_cnt_o + 8'd1;
        end
      end else if (res.valid_o && res.ready_i) begin
        res.valid_o <= 1'b0;
      end
    end
  end

endmodule
